zorro_buffer_sequencer: RTL and testbench
=========================================

// Module: zorro_buffer_sequencer
// PURPOSE
//  Clocked, parametrised Zorro III address/data buffer controller for the A4091 bus interface.
//  Drives the 74xx address/data buffer enables, the direction controls and the data latch
//  (DBLT) from registered state rather than raw combinational terms.
//  Adds three things:
//   - enforced turnaround dead-time whenever the data buffer direction reverses;
//   - a general DS_n -> A1/A0/SIZ decoder for 2 or 4 byte lanes;
//   - a lane-mask error flag.
// PARAMETERS
//  LANES        4  byte lanes / DS_n width; legal values 2 or 4
//  TURN_CYCLES  2  dead CLK cycles, all data buffers off, before driving the reverse direction; 0 = none
//  CNT_W        2  turnaround counter width; must hold TURN_CYCLES
// PORTS
//  CLK          in   1          bus clock; all registers on rising edge
//  RESET_n      in   1          synchronous active-low reset
//  MASTER_n     in   1          Zorro MASTER_n
//  Z_FCS_n      in   1          Zorro full cycle strobe, active low
//  slavecycle   in   1          board is addressed as slave
//  mastercycle  in   1          board owns the Zorro bus (DMA)
//  slave        in   1          SCSI side is the target
//  READ         in   1          Zorro READ
//  DOE          in   1          data output enable / data time
//  DTACK_n      in   1          data acknowledge, active low
//  dma_aboel    in   1          DMA request to drive low address
//  dma_aboeh    in   1          DMA request to drive high address
//  DS_n         in   LANES      data strobes, active low; DS_n[LANES-1] = byte address 0
//  FCS          out  1          !Z_FCS_n, combinational (U1/U4 latch enable)
//  BMASTER      out  1          !MASTER_n, combinational
//  ABOEL_n      out  1          registered low address buffer enable
//  ABOEH_n      out  1          registered high address buffer enable
//  DBOE_n       out  1          registered data buffer enable
//  D2Z_n        out  1          registered direction: board to Zorro
//  Z2D_n        out  1          registered direction: Zorro to board
//  DBLT         out  1          registered data latch enable
//  addrl        out  2          A1/A0 derived from DS_n
//  siz          out  2          68030 SIZ; 00 = 4 bytes
//  lane_err     out  1          captured DS_n was empty or non-contiguous
//  busy         out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset (RESET_n=0 at an edge, from any state, including mid-cycle):
//   - FSM goes to IDLE.
//   - ABOEL_n=ABOEH_n=DBOE_n=D2Z_n=Z2D_n=1; DBLT=0.
//   - addrl=siz=00; lane_err=0; busy=0; last_dir=NONE.
//  ABOEL_n/ABOEH_n:
//   - registered each cycle as !(slavecycle | (mastercycle & dma_aboel/h)).
//   - 1 CLK latency; independent of the FSM.
//  Direction (evaluated at FCS capture):
//   - OUT = (slavecycle&slave&READ) | (mastercycle&!slave&!READ).
//   - IN  = (slavecycle&slave&!READ) | (mastercycle&!slave&READ).
//   - else NONE (self-access or foreign cycle).
//  FSM states: IDLE, TURN, DATA, LATCHED, HOLD.
//   IDLE:
//    - on sampled Z_FCS_n=0, latch dir:
//      - dir NONE -> HOLD;
//      - dir != last_dir, last_dir != NONE and TURN_CYCLES > 0 -> TURN (cnt = TURN_CYCLES-1);
//      - otherwise -> DATA.
//   TURN:
//    - all data outputs deasserted; cnt decrements; at cnt==0 -> DATA.
//   DATA:
//    - D2Z_n=0 (OUT) or Z2D_n=0 (IN); last_dir <= dir on entry.
//    - IN: DBOE_n=0 from the first DATA cycle.
//    - OUT: DBOE_n=0 only in cycles after DOE is sampled 1.
//    - DOE=1 & DTACK_n=0 sampled -> LATCHED, DBLT=1 the following cycle.
//   LATCHED:
//    - DBLT, DBOE_n and direction held until FCS release.
//   HOLD:
//    - all data outputs off until FCS release.
//  Any non-IDLE state: sampled Z_FCS_n=1 -> IDLE; all data outputs deasserted 1 CLK after the release.
//   - Release has priority over a same-cycle DTACK or turn count expiry.
//  Direction outputs are never both low; DBOE_n is never low while both direction outputs are high.
//  Lane decode:
//   - DS_n captured on the first cycle of a cycle with DOE=1; held until the next capture.
//   - Active bit i corresponds to byte address LANES-1-i.
//   - addrl = lowest active byte address; siz = (span of first..last active lane) mod 4.
//   - LANES=2: addrl[1]=0.
//   - Empty or non-contiguous mask: lane_err=1, siz/addrl computed from the span, cycle still served.
//  Must match the existing 4-lane table: 1110->a11 s01, 1100->a10 s10, 1001->a01 s10, 0000->a00 s00.
// TESTING
//  1. Slave read, TURN_CYCLES=2, last_dir=NONE: FCS low, DOE high at cycle 3, DTACK low at cycle 4
//     -> D2Z_n=0 at cycle 1, DBOE_n=0 at cycle 4, DBLT=1 at cycle 5, all off 1 CLK after FCS high.
//  2. Slave read followed by slave write -> exactly 2 cycles with all data outputs off before Z2D_n=0;
//     repeat with TURN_CYCLES=0 -> no gap.
//  3. Self-access (mastercycle, slave=1) -> HOLD; DBOE_n, D2Z_n and Z2D_n stay 1; DBLT stays 0.
//  4. DS_n sweep of all 16 codes (LANES=4) -> addrl/siz match the table;
//     1010 and 1111 -> lane_err=1.
//  5. FCS release in the same cycle as DTACK -> DBLT never rises;
//     RESET_n=0 while LATCHED -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/zorro_buffer_sequencer.sv
// Zorro III buffer sequencer: registered address/data buffer enables, direction, DBLT and DS_n lane decode.
// Outputs follow sampled inputs by 1 CLK; direction reversals insert TURN_CYCLES dead cycles; no backpressure.
module zorro_buffer_sequencer #(
  parameter int LANES       = 4,
  parameter int TURN_CYCLES = 2,
  parameter int CNT_W       = 2
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             MASTER_n,
  input  logic             Z_FCS_n,
  input  logic             slavecycle,
  input  logic             mastercycle,
  input  logic             slave,
  input  logic             READ,
  input  logic             DOE,
  input  logic             DTACK_n,
  input  logic             dma_aboel,
  input  logic             dma_aboeh,
  input  logic [LANES-1:0] DS_n,
  output logic             FCS,
  output logic             BMASTER,
  output logic             ABOEL_n,
  output logic             ABOEH_n,
  output logic             DBOE_n,
  output logic             D2Z_n,
  output logic             Z2D_n,
  output logic             DBLT,
  output logic [1:0]       addrl,
  output logic [1:0]       siz,
  output logic             lane_err,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_TURN, S_DATA, S_LATCHED, S_HOLD} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_OUT, DIR_IN} dir_t;

  localparam bit               TURN_EN   = (TURN_CYCLES > 0);
  localparam logic [CNT_W-1:0] TURN_INIT = CNT_W'(TURN_EN ? TURN_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d, last_dir_q, last_dir_d, cyc_dir;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             doe_seen_q, doe_seen_d;
  logic             aboel_q, aboeh_q, dboe_q, d2z_q, z2d_q, dblt_q;
  logic             dboe_d, d2z_d, z2d_d, dblt_d, drive;
  logic [1:0]       addrl_q, siz_q;
  logic             lane_err_q;
  logic [1:0]       first_b, last_b;
  logic [2:0]       n_act, span;
  logic             any_act, lane_cap;

  assign FCS     = ~Z_FCS_n;
  assign BMASTER = ~MASTER_n;

  always_comb begin
    cyc_dir = DIR_NONE;
    if ((slavecycle & slave & READ) | (mastercycle & ~slave & ~READ)) begin
      cyc_dir = DIR_OUT;
    end else if ((slavecycle & slave & ~READ) | (mastercycle & ~slave & READ)) begin
      cyc_dir = DIR_IN;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    case (state_q)
      S_IDLE: begin
        if (!Z_FCS_n) begin
          dir_d = cyc_dir;
          if (cyc_dir == DIR_NONE) begin
            state_d = S_HOLD;
          end else if (TURN_EN && last_dir_q != DIR_NONE && cyc_dir != last_dir_q) begin
            state_d = S_TURN;
            cnt_d   = TURN_INIT;
          end else begin
            state_d    = S_DATA;
            last_dir_d = cyc_dir;
          end
        end
      end
      // FCS release is tested first so it wins over count expiry and DTACK.
      S_TURN: begin
        if (Z_FCS_n) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d    = S_DATA;
          last_dir_d = dir_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (Z_FCS_n) begin
          state_d = S_IDLE;
        end else if (DOE && !DTACK_n) begin
          state_d = S_LATCHED;
        end
      end
      S_LATCHED, S_HOLD: begin
        if (Z_FCS_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    doe_seen_d = ~Z_FCS_n & (doe_seen_q | DOE);
    drive      = (state_d == S_DATA) || (state_d == S_LATCHED);
    d2z_d      = ~(drive && dir_d == DIR_OUT);
    z2d_d      = ~(drive && dir_d == DIR_IN);
    dboe_d     = ~(drive && (dir_d == DIR_IN || doe_seen_d));
    dblt_d     = (state_d == S_LATCHED);
  end

  // Byte address b lives on DS_n[LANES-1-b]; span is taken from first to last active byte.
  always_comb begin
    first_b = '0;
    last_b  = '0;
    n_act   = '0;
    any_act = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      if (!DS_n[LANES-1-b]) begin
        if (!any_act) first_b = 2'(b);
        last_b  = 2'(b);
        n_act   = n_act + 3'd1;
        any_act = 1'b1;
      end
    end
    span = any_act ? ({1'b0, last_b} - {1'b0, first_b} + 3'd1) : 3'd0;
  end

  assign lane_cap = ~Z_FCS_n & DOE & ~doe_seen_q;

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dir_q      <= DIR_NONE;
      last_dir_q <= DIR_NONE;
      doe_seen_q <= 1'b0;
      aboel_q    <= 1'b1;
      aboeh_q    <= 1'b1;
      dboe_q     <= 1'b1;
      d2z_q      <= 1'b1;
      z2d_q      <= 1'b1;
      dblt_q     <= 1'b0;
      addrl_q    <= 2'b00;
      siz_q      <= 2'b00;
      lane_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      doe_seen_q <= doe_seen_d;
      aboel_q    <= ~(slavecycle | (mastercycle & dma_aboel));
      aboeh_q    <= ~(slavecycle | (mastercycle & dma_aboeh));
      dboe_q     <= dboe_d;
      d2z_q      <= d2z_d;
      z2d_q      <= z2d_d;
      dblt_q     <= dblt_d;
      if (lane_cap) begin
        addrl_q    <= first_b;
        siz_q      <= span[1:0];
        lane_err_q <= ~any_act | (n_act != span);
      end
    end
  end

  assign ABOEL_n  = aboel_q;
  assign ABOEH_n  = aboeh_q;
  assign DBOE_n   = dboe_q;
  assign D2Z_n    = d2z_q;
  assign Z2D_n    = z2d_q;
  assign DBLT     = dblt_q;
  assign addrl    = addrl_q;
  assign siz      = siz_q;
  assign lane_err = lane_err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_zorro_buffer_sequencer.sv
// Bench for zorro_buffer_sequencer: one TURN_CYCLES=2 instance and one TURN_CYCLES=0 instance
// driven with identical bus cycles.
module tb_zorro_buffer_sequencer;

  localparam int TURN0 = 2;
  localparam int TURN1 = 0;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET_n, MASTER_n, Z_FCS_n, slavecycle, mastercycle, slave, READ;
  logic       DOE, DTACK_n, dma_aboel, dma_aboeh;
  logic [3:0] DS_n;

  logic [1:0] o_fcs, o_bm, o_aboel, o_aboeh, o_dboe, o_d2z, o_z2d, o_dblt, o_err, o_busy;
  logic [1:0] o_addrl [2];
  logic [1:0] o_siz   [2];

  int tests = 0;
  int fails = 0;

  zorro_buffer_sequencer #(.LANES(4), .TURN_CYCLES(TURN0), .CNT_W(2)) u_t2 (
    .CLK(CLK), .RESET_n(RESET_n), .MASTER_n(MASTER_n), .Z_FCS_n(Z_FCS_n),
    .slavecycle(slavecycle), .mastercycle(mastercycle), .slave(slave), .READ(READ),
    .DOE(DOE), .DTACK_n(DTACK_n), .dma_aboel(dma_aboel), .dma_aboeh(dma_aboeh), .DS_n(DS_n),
    .FCS(o_fcs[0]), .BMASTER(o_bm[0]), .ABOEL_n(o_aboel[0]), .ABOEH_n(o_aboeh[0]),
    .DBOE_n(o_dboe[0]), .D2Z_n(o_d2z[0]), .Z2D_n(o_z2d[0]), .DBLT(o_dblt[0]),
    .addrl(o_addrl[0]), .siz(o_siz[0]), .lane_err(o_err[0]), .busy(o_busy[0])
  );

  zorro_buffer_sequencer #(.LANES(4), .TURN_CYCLES(TURN1), .CNT_W(2)) u_t0 (
    .CLK(CLK), .RESET_n(RESET_n), .MASTER_n(MASTER_n), .Z_FCS_n(Z_FCS_n),
    .slavecycle(slavecycle), .mastercycle(mastercycle), .slave(slave), .READ(READ),
    .DOE(DOE), .DTACK_n(DTACK_n), .dma_aboel(dma_aboel), .dma_aboeh(dma_aboeh), .DS_n(DS_n),
    .FCS(o_fcs[1]), .BMASTER(o_bm[1]), .ABOEL_n(o_aboel[1]), .ABOEH_n(o_aboeh[1]),
    .DBOE_n(o_dboe[1]), .D2Z_n(o_d2z[1]), .Z2D_n(o_z2d[1]), .DBLT(o_dblt[1]),
    .addrl(o_addrl[1]), .siz(o_siz[1]), .lane_err(o_err[1]), .busy(o_busy[1])
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference lane decode: leading inactive strobes give the first byte, trailing ones the last.
  function automatic logic [4:0] lane_ref(input logic [3:0] ds);
    int lead, trail, first, last, span, nact;
    lead = 0;
    while (lead < 4 && ds[3-lead]) lead++;
    if (lead == 4) return 5'b1_00_00;
    trail = 0;
    while (ds[trail]) trail++;
    first = lead;
    last  = 3 - trail;
    span  = last - first + 1;
    nact  = 4 - $countones(ds);
    return {nact != span, 2'(first), 2'(span % 4)};
  endfunction

  function automatic int bus_dir();
    if ((slavecycle && slave && READ) || (mastercycle && !slave && !READ)) return 1;
    if ((slavecycle && slave && !READ) || (mastercycle && !slave && READ)) return 2;
    return 0;
  endfunction

  // Model: each bus cycle is a timeline counted in edges since FCS capture.
  bit         m_valid = 1'b0;
  bit         m_act [2];
  bit         m_lat [2];
  bit         m_doe [2];
  int         m_dir [2];
  int         m_last[2];
  int         m_t   [2];
  int         m_gap [2];
  logic       e_aboel, e_aboeh, e_err;
  logic [1:0] e_addrl, e_siz;

  always @(posedge CLK) begin : model
    logic [4:0] lv;
    bit         on;
    if (!RESET_n) begin
      m_valid = 1'b1;
      e_aboel = 1'b1; e_aboeh = 1'b1;
      e_addrl = 2'b00; e_siz = 2'b00; e_err = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_lat[k] = 0; m_doe[k] = 0;
        m_dir[k] = 0; m_last[k] = 0; m_t[k] = 0; m_gap[k] = 0;
      end
    end else begin
      e_aboel = !(slavecycle || (mastercycle && dma_aboel));
      e_aboeh = !(slavecycle || (mastercycle && dma_aboeh));
      if (!Z_FCS_n && DOE && !m_doe[0]) begin
        lv = lane_ref(DS_n);
        e_err = lv[4]; e_addrl = lv[3:2]; e_siz = lv[1:0];
      end
      for (int k = 0; k < 2; k++) begin
        if (!m_act[k]) begin
          if (!Z_FCS_n) begin
            m_act[k] = 1; m_dir[k] = bus_dir(); m_t[k] = 0; m_lat[k] = 0; m_doe[k] = DOE;
            m_gap[k] = (m_dir[k] != 0 && m_last[k] != 0 && m_dir[k] != m_last[k])
                       ? ((k == 0) ? TURN0 : TURN1) : 0;
            if (m_dir[k] != 0 && m_gap[k] == 0) m_last[k] = m_dir[k];
          end
        end else if (Z_FCS_n) begin
          m_act[k] = 0; m_lat[k] = 0; m_doe[k] = 0;
        end else begin
          if (m_dir[k] != 0 && m_t[k] >= m_gap[k] && DOE && !DTACK_n) m_lat[k] = 1;
          m_doe[k] = m_doe[k] | DOE;
          m_t[k]++;
          if (m_dir[k] != 0 && m_t[k] == m_gap[k]) m_last[k] = m_dir[k];
        end
      end
    end
    #1;
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        on = m_act[k] && m_dir[k] != 0 && m_t[k] >= m_gap[k];
        chk($sformatf("fcs[%0d]", k), o_fcs[k], !Z_FCS_n);
        chk($sformatf("bmaster[%0d]", k), o_bm[k], !MASTER_n);
        chk($sformatf("aboel[%0d]", k), o_aboel[k], e_aboel);
        chk($sformatf("aboeh[%0d]", k), o_aboeh[k], e_aboeh);
        chk($sformatf("d2z[%0d]", k), o_d2z[k], !(on && m_dir[k] == 1));
        chk($sformatf("z2d[%0d]", k), o_z2d[k], !(on && m_dir[k] == 2));
        chk($sformatf("dboe[%0d]", k), o_dboe[k], !(on && (m_dir[k] == 2 || m_doe[k] || m_lat[k])));
        chk($sformatf("dblt[%0d]", k), o_dblt[k], on && m_lat[k]);
        chk($sformatf("busy[%0d]", k), o_busy[k], m_act[k]);
        chk($sformatf("addrl[%0d]", k), o_addrl[k], e_addrl);
        chk($sformatf("siz[%0d]", k), o_siz[k], e_siz);
        chk($sformatf("lane_err[%0d]", k), o_err[k], e_err);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic idle_inputs();
    Z_FCS_n = 1'b1; DOE = 1'b0; DTACK_n = 1'b1;
    slavecycle = 1'b0; mastercycle = 1'b0; slave = 1'b0; READ = 1'b0;
    dma_aboel = 1'b0; dma_aboeh = 1'b0;
  endtask

  task automatic lane_cycle(input logic [3:0] code);
    idle_inputs();
    slavecycle = 1'b1; slave = 1'b1; READ = 1'b1;
    Z_FCS_n = 1'b0; DOE = 1'b1; DS_n = code;
    cyc(1);
    DS_n = ~code;
    cyc(1);
    Z_FCS_n = 1'b1; DOE = 1'b0;
    cyc(1);
  endtask

  logic [3:0] lt_ds  [6] = '{4'b1110, 4'b1100, 4'b1001, 4'b0000, 4'b1010, 4'b1111};
  logic [4:0] lt_exp [6] = '{5'b0_11_01, 5'b0_10_10, 5'b0_01_10, 5'b0_00_00, 5'b1_01_11, 5'b1_00_00};

  initial begin
    RESET_n = 1'b0; MASTER_n = 1'b1; DS_n = 4'hF;
    idle_inputs();
    cyc(2);
    chk("rst_dboe", o_dboe[0], 1); chk("rst_d2z", o_d2z[0], 1); chk("rst_z2d", o_z2d[0], 1);
    chk("rst_dblt", o_dblt[0], 0); chk("rst_busy", o_busy[0], 0); chk("rst_aboel", o_aboel[0], 1);
    RESET_n = 1'b1; MASTER_n = 1'b0;
    cyc(1);
    chk("bmaster_lit", o_bm[0], 1);

    // Slave read, no previous direction.
    slavecycle = 1'b1; slave = 1'b1; READ = 1'b1; Z_FCS_n = 1'b0; DS_n = 4'b0000;
    cyc(1);
    chk("t1_d2z_c1", o_d2z[0], 0); chk("t1_dboe_c1", o_dboe[0], 1); chk("t1_aboel_c1", o_aboel[0], 0);
    cyc(2);
    chk("t1_dboe_c3", o_dboe[0], 1);
    DOE = 1'b1;
    cyc(1);
    chk("t1_dboe_c4", o_dboe[0], 0); chk("t1_dblt_c4", o_dblt[0], 0);
    DTACK_n = 1'b0;
    cyc(1);
    chk("t1_dblt_c5", o_dblt[0], 1); chk("t1_addrl", o_addrl[0], 2'b00);
    Z_FCS_n = 1'b1; DOE = 1'b0; DTACK_n = 1'b1;
    cyc(1);
    chk("t1_rel_dblt", o_dblt[0], 0); chk("t1_rel_d2z", o_d2z[0], 1);
    chk("t1_rel_dboe", o_dboe[0], 1); chk("t1_rel_busy", o_busy[0], 0);

    // Slave write straight after the read: turnaround on TURN_CYCLES=2 only.
    READ = 1'b0; Z_FCS_n = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cyc(1);
      chk($sformatf("t2_z2d_turn2_c%0d", c), o_z2d[0], (c >= 3) ? 1'b0 : 1'b1);
      chk($sformatf("t2_dboe_turn2_c%0d", c), o_dboe[0], (c >= 3) ? 1'b0 : 1'b1);
      chk($sformatf("t2_d2z_turn2_c%0d", c), o_d2z[0], 1);
      chk($sformatf("t2_z2d_turn0_c%0d", c), o_z2d[1], 0);
    end
    DOE = 1'b1; DTACK_n = 1'b0;
    cyc(1);
    chk("t2_dblt_turn2", o_dblt[0], 1); chk("t2_dblt_turn0", o_dblt[1], 1);
    idle_inputs();
    cyc(1);

    // Self-access: HOLD with all data outputs off.
    mastercycle = 1'b1; slave = 1'b1; READ = 1'b1; dma_aboel = 1'b1;
    Z_FCS_n = 1'b0; DOE = 1'b1; DTACK_n = 1'b0; DS_n = 4'b1100;
    cyc(3);
    chk("t3_busy", o_busy[0], 1); chk("t3_dboe", o_dboe[0], 1); chk("t3_d2z", o_d2z[0], 1);
    chk("t3_z2d", o_z2d[0], 1); chk("t3_dblt", o_dblt[0], 0); chk("t3_dblt_t0", o_dblt[1], 0);
    chk("t3_aboel", o_aboel[0], 0); chk("t3_aboeh", o_aboeh[0], 1); chk("t3_addrl", o_addrl[0], 2'b10);
    idle_inputs();
    cyc(1);

    // DMA write (OUT after IN), then a write released while still turning around.
    MASTER_n = 1'b1;
    mastercycle = 1'b1; slave = 1'b0; READ = 1'b0; dma_aboeh = 1'b1; Z_FCS_n = 1'b0;
    cyc(2);
    DOE = 1'b1;
    cyc(2);
    DTACK_n = 1'b0;
    cyc(2);
    idle_inputs();
    cyc(1);
    slavecycle = 1'b1; slave = 1'b1; READ = 1'b0; Z_FCS_n = 1'b0;
    cyc(1);
    Z_FCS_n = 1'b1;
    cyc(2);
    MASTER_n = 1'b0;

    // Full DS_n sweep, then the fixed lane table.
    for (int code = 0; code < 16; code++) lane_cycle(4'(code));
    for (int i = 0; i < 6; i++) begin
      lane_cycle(lt_ds[i]);
      chk($sformatf("lane_%b_addrl", lt_ds[i]), o_addrl[0], lt_exp[i][3:2]);
      chk($sformatf("lane_%b_siz", lt_ds[i]), o_siz[0], lt_exp[i][1:0]);
      chk($sformatf("lane_%b_err", lt_ds[i]), o_err[0], lt_exp[i][4]);
    end

    // Release in the same cycle as DTACK: DBLT must stay low.
    idle_inputs();
    slavecycle = 1'b1; slave = 1'b1; READ = 1'b1; Z_FCS_n = 1'b0;
    cyc(1);
    DOE = 1'b1;
    cyc(1);
    Z_FCS_n = 1'b1; DTACK_n = 1'b0;
    cyc(1);
    chk("t5_rel_dblt0", o_dblt[0], 0); chk("t5_rel_dblt1", o_dblt[1], 0); chk("t5_rel_busy", o_busy[0], 0);
    cyc(1);
    chk("t5_rel_dblt_next", o_dblt[0], 0);
    DTACK_n = 1'b1; DOE = 1'b0;

    // Reset while LATCHED.
    Z_FCS_n = 1'b0; DS_n = 4'b1010; DOE = 1'b1;
    cyc(1);
    DTACK_n = 1'b0;
    cyc(1);
    chk("t5_latched_dblt", o_dblt[0], 1); chk("t5_latched_err", o_err[0], 1);
    RESET_n = 1'b0;
    cyc(1);
    chk("t5_rst_aboel", o_aboel[0], 1); chk("t5_rst_aboeh", o_aboeh[0], 1);
    chk("t5_rst_dboe", o_dboe[0], 1); chk("t5_rst_d2z", o_d2z[0], 1); chk("t5_rst_z2d", o_z2d[0], 1);
    chk("t5_rst_dblt", o_dblt[0], 0); chk("t5_rst_addrl", o_addrl[0], 0); chk("t5_rst_siz", o_siz[0], 0);
    chk("t5_rst_err", o_err[0], 0); chk("t5_rst_busy", o_busy[0], 0);
    RESET_n = 1'b1;
    idle_inputs();
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
